// File: rtl/srsc_pkg.sv
// Shared types and constants for the SRSC pixel pipeline.
// Fixed-point formats for the reciprocal path live here.
package srsc_pkg;

    localparam int Q_FRAC_INV = 8;
    localparam int INV_W      = 10;
    localparam int T_W        = 8;

    localparam logic [INV_W-1:0] INV_SAT = 10'h3FF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/restoring_div_step.sv
// One restoring-division step: shift in a dividend bit,
// subtract the divisor when it fits.
module restoring_div_step
    import srsc_pkg::*;
(
    input  logic [T_W:0] rem_in,
    input  logic         bit_in,
    input  logic [T_W:0] d,
    output logic [T_W:0] rem_out,
    output logic         q_bit
);

    logic [T_W+1:0] sh;
    logic           ge;

    assign sh = {rem_in, bit_in};
    assign ge = (sh >= {1'b0, d});

    // rem_in < d <= 255 keeps the restored value inside 9 bits
    assign rem_out = ge ? (T_W+1)'(sh - {1'b0, d}) : sh[T_W:0];
    assign q_bit   = ge;

endmodule

// File: rtl/inv_trans_divider_srsc.sv
// Iterative 1/t (Q2.8) from a Q0.8 transmission estimate,
// with the (Ic-Ac) side-band carried alongside the result.
module inv_trans_divider_srsc
    import srsc_pkg::*;
#(
    parameter logic [T_W-1:0] T_MIN      = 8'd26,
    parameter int             DIV_CYCLES = 17
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [T_W-1:0]   trans,
    input  logic [T_W-1:0]   ic_minus_ac,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [INV_W-1:0] inv_trans,
    output logic [T_W-1:0]   ic_minus_ac_o
);

    localparam int CW = $clog2(DIV_CYCLES);

    localparam logic [DIV_CYCLES-1:0] DIVIDEND =
        DIV_CYCLES'(1) << (DIV_CYCLES - 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(DIV_CYCLES - 1);
    localparam logic [DIV_CYCLES-1:0] SAT_Q = DIV_CYCLES'(INV_SAT);

    if (T_MIN < 1) begin : g_tmin_chk
        $error("T_MIN must be at least 1");
    end

    state_t                state;
    logic [T_W:0]          d;
    logic [T_W:0]          rem;
    logic [DIV_CYCLES-1:0] q;
    logic [CW-1:0]         count;
    logic [T_W-1:0]        side;

    logic [T_W:0]          rem_nxt;
    logic                  q_bit;

    restoring_div_step u_step (
        .rem_in  (rem),
        .bit_in  (DIVIDEND[count]),
        .d       (d),
        .rem_out (rem_nxt),
        .q_bit   (q_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            in_ready      <= 1'b0;
            out_valid     <= 1'b0;
            inv_trans     <= '0;
            ic_minus_ac_o <= '0;
            d             <= '0;
            rem           <= '0;
            q             <= '0;
            count         <= '0;
            side          <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        d        <= (trans < T_MIN) ? {1'b0, T_MIN}
                                                    : {1'b0, trans};
                        side     <= ic_minus_ac;
                        rem      <= '0;
                        q        <= '0;
                        count    <= CNT_LOAD;
                        in_ready <= 1'b0;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    rem      <= rem_nxt;
                    q[count] <= q_bit;
                    if (count == '0) begin
                        state <= DONE;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                DONE: begin
                    if (!out_valid) begin
                        out_valid     <= 1'b1;
                        inv_trans     <= (q > SAT_Q) ? INV_SAT
                                                     : q[INV_W-1:0];
                        ic_minus_ac_o <= side;
                    end else if (out_ready) begin
                        // new beats wait for the IDLE cycle that follows
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inv_trans_divider_srsc.sv
// Scoreboard bench for inv_trans_divider_srsc: random and directed
// beats against a plain-arithmetic reciprocal model.
module tb_inv_trans_divider_srsc;

    typedef struct {
        logic [7:0] t;
        logic [7:0] ic;
        logic [9:0] inv;
        int         acc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] trans;
    logic [7:0] ic_minus_ac;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [9:0] inv_trans;
    logic [7:0] ic_minus_ac_o;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   rdy_mode = 0;

    inv_trans_divider_srsc dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .trans         (trans),
        .ic_minus_ac   (ic_minus_ac),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .inv_trans     (inv_trans),
        .ic_minus_ac_o (ic_minus_ac_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    function automatic logic [9:0] ref_inv(input logic [7:0] t);
        int dd;
        int qq;
        dd = (t < 26) ? 26 : int'(t);
        qq = 65536 / dd;
        return (qq > 1023) ? 10'd1023 : 10'(qq);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // monitor: latency on rise, stability under stall, compare on handshake
    logic       pv = 1'b0;
    logic       pr = 1'b0;
    logic [9:0] pinv = '0;
    logic [7:0] pic = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            pv = 1'b0;
        end else begin
            if (out_valid && !pv) begin
                if (sb.size() == 0)
                    check("unexpected_out", 1, 0);
                else
                    check("latency", cyc - sb[0].acc, 18);
            end
            if (out_valid && pv && !pr) begin
                check("hold_inv", int'(inv_trans), int'(pinv));
                check("hold_ic", int'(ic_minus_ac_o), int'(pic));
            end
            if (out_valid)
                check("in_ready_busy", int'(in_ready), 0);
            if (out_valid && out_ready && sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check($sformatf("inv t=%0d", e.t),
                      int'(inv_trans), int'(e.inv));
                check($sformatf("ic t=%0d", e.t),
                      int'(ic_minus_ac_o), int'(e.ic));
            end
            pv   = out_valid;
            pr   = out_ready;
            pinv = inv_trans;
            pic  = ic_minus_ac_o;
        end
    end

    task automatic send(input logic [7:0] t, input logic [7:0] ic);
        int n;
        exp_t e;
        @(negedge clk);
        in_valid    = 1'b1;
        trans       = t;
        ic_minus_ac = ic;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 0, 1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            e.t   = t;
            e.ic  = ic;
            e.inv = ref_inv(t);
            e.acc = cyc;
            sb.push_back(e);
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_empty(input int limit);
        int n;
        n = 0;
        while (sb.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("drain", sb.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        trans       = '0;
        ic_minus_ac = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_inv", int'(inv_trans), 0);
        check("rst_ic", int'(ic_minus_ac_o), 0);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("ready_after_rst", int'(in_ready), 1);

        send(8'd255, 8'd100);
        send(8'd128, 8'd1);
        send(8'd192, 8'd2);
        send(8'd64, 8'd3);
        send(8'd0, 8'd4);
        send(8'd26, 8'd5);
        send(8'd25, 8'd6);
        wait_empty(200);

        // backpressure: result must sit still for 10 cycles
        rdy_mode = 2;
        send(8'd200, 8'd77);
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid", int'(out_valid), 1);
        repeat (10) begin
            @(negedge clk);
            check("bp_valid_held", int'(out_valid), 1);
            check("bp_in_ready", int'(in_ready), 0);
        end
        rdy_mode = 0;
        wait_empty(20);
        repeat (25) @(negedge clk);
        check("bp_one_beat", int'(out_valid), 0);

        // reset during CALC aborts the beat
        send(8'd100, 8'd55);
        repeat (8) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_ready", int'(in_ready), 0);
        check("mid_rst_inv", int'(inv_trans), 0);
        check("mid_rst_ic", int'(ic_minus_ac_o), 0);
        sb.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(8'd128, 8'd9);
        wait_empty(40);

        // random stream with random downstream stalls
        rdy_mode = 1;
        repeat (50) begin
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end
        wait_empty(2000);
        rdy_mode = 0;
        repeat (25) @(negedge clk);
        check("stream_idle", int'(out_valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
